// File: rtl/input_buffer_pkg.sv
// input_buffer_pkg: flit format, flit-type encodings and the type-field decoder.
package input_buffer_pkg;
    localparam int DATAW = 15;
    localparam int FTYPE_MSB = DATAW;
    localparam int FTYPE_LSB = DATAW - 1;
    typedef enum logic [1:0] {HEAD = 2'd0, BODY = 2'd1, TAIL = 2'd2, HEADTAIL = 2'd3} ftype_t;
    function automatic ftype_t ftype(input logic [DATAW:0] f);
        return ftype_t'(f[FTYPE_MSB:FTYPE_LSB]);
    endfunction
endpackage

// File: rtl/input_buffer_fifo_mem.sv
// fifo_mem: flit storage array, synchronous write and combinational read.
module fifo_mem #(
    parameter int DEPTH = 4,
    parameter int AW = 2,
    parameter int W = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/input_buffer.sv
// input_buffer: router input FIFO with route-compute / switch-allocation sequencing per packet.
module input_buffer
    import input_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTRW = 1
) (
    input  logic           clk,
    input  logic           rst_,
    input  logic [DATAW:0] idata,
    input  logic           iwe,
    output logic [DATAW:0] odata,
    output logic           rt_en,
    output logic           req,
    input  logic           grt,
    output logic           credit,
    output logic           empty,
    output logic           full,
    output logic           ovf,
    output logic           err
);
    typedef enum logic [1:0] {IDLE, RC, SA} state_t;
    state_t          state;
    logic [PTRW:0]   rd_ptr, wr_ptr;
    logic [PTRW+1:0] count;
    ftype_t          head;
    logic            bad_head, deq, wr, is_tail;

    fifo_mem #(.DEPTH(DEPTH), .AW(PTRW + 1), .W(DATAW + 1)) u_mem (
        .clk(clk), .we(wr), .waddr(wr_ptr), .wdata(idata), .raddr(rd_ptr), .rdata(odata)
    );

    assign head     = ftype(odata);
    assign is_tail  = head == TAIL || head == HEADTAIL;
    assign empty    = count == '0;
    assign full     = count == (PTRW + 2)'(DEPTH);
    // A packet must start with a head flit; stray body/tail flits are flushed.
    assign bad_head = state == IDLE && !empty && (head == BODY || head == TAIL);
    assign req      = state == SA && !empty;
    assign deq      = bad_head || (req && grt);
    assign wr       = iwe && (!full || deq);
    assign credit   = deq;
    assign rt_en    = state == RC;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            state  <= IDLE;
            ovf    <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + (PTRW + 1)'(1);
            if (deq) rd_ptr <= rd_ptr + (PTRW + 1)'(1);
            if (wr && !deq) count <= count + (PTRW + 2)'(1);
            else if (deq && !wr) count <= count - (PTRW + 2)'(1);
            if (iwe && !wr) ovf <= 1'b1;
            if (bad_head) err <= 1'b1;
            state <= state == IDLE ? ((!empty && !bad_head) ? RC : IDLE) :
                     state == RC   ? SA :
                     (deq && is_tail) ? IDLE : SA;
        end
    end
endmodule

// File: tb/tb_input_buffer.sv
// tb_input_buffer: scoreboard bench; accepted flits are queued and matched on each credit pulse.
module tb_input_buffer;
    import input_buffer_pkg::*;
    logic           clk = 1'b0, rst_ = 1'b0, iwe = 1'b0, grt = 1'b0;
    logic [DATAW:0] idata = '0;
    logic [DATAW:0] odata;
    logic           rt_en, req, credit, empty, full, ovf, err;
    int             checks = 0, errors = 0, rt_cnt = 0, cr_cnt = 0;
    bit             full_seen = 0;
    logic [DATAW:0] sb [$];
    logic [1:0]     t2 [4] = '{HEAD, BODY, BODY, TAIL};
    logic [1:0]     t3 [5] = '{HEAD, BODY, BODY, TAIL, HEAD};
    logic [1:0]     t4 [4] = '{HEAD, BODY, BODY, BODY};

    input_buffer #(.DEPTH(4), .PTRW(1)) dut (
        .clk(clk), .rst_(rst_), .idata(idata), .iwe(iwe), .odata(odata), .rt_en(rt_en),
        .req(req), .grt(grt), .credit(credit), .empty(empty), .full(full), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rt_en) rt_cnt++;
        if (full) full_seen = 1;
        if (credit) begin
            cr_cnt++;
            if (sb.size() == 0) check("credit_unexpected", 32'(credit), 32'(0));
            else check("flit_order", 32'(odata), 32'(sb.pop_front()));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 iwe = 1'b0;
        end
    endtask

    task automatic wr(input logic [1:0] t, input logic [13:0] p, input bit acc);
        @(posedge clk);
        #1 iwe = 1'b1;
        idata = {t, p};
        if (acc) sb.push_back({t, p});
    endtask

    task automatic do_reset;
        @(posedge clk);
        #1 rst_ = 1'b0;
        iwe = 1'b0;
        grt = 1'b0;
        sb.delete();
        #1;
        check("rst_empty", 32'(empty), 32'(1));
        check("rst_full", 32'(full), 32'(0));
        check("rst_req", 32'(req), 32'(0));
        check("rst_rt_en", 32'(rt_en), 32'(0));
        check("rst_credit", 32'(credit), 32'(0));
        check("rst_ovf", 32'(ovf), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        @(posedge clk);
        #1 rst_ = 1'b1;
        rt_cnt = 0;
        cr_cnt = 0;
        full_seen = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        do_reset();
        // single-flit packet, minimum latency
        grt = 1'b1;
        wr(HEADTAIL, 14'h0AA, 1);
        @(negedge clk) check("t1_c0_rt_en", 32'(rt_en), 32'(0));
        cyc(1);
        @(negedge clk) check("t1_c1_rt_en", 32'(rt_en), 32'(0));
        check("t1_c1_empty", 32'(empty), 32'(0));
        cyc(1);
        @(negedge clk) check("t1_c2_rt_en", 32'(rt_en), 32'(1));
        check("t1_c2_req", 32'(req), 32'(0));
        cyc(1);
        @(negedge clk) check("t1_c3_req", 32'(req), 32'(1));
        check("t1_c3_credit", 32'(credit), 32'(1));
        cyc(1);
        @(negedge clk) check("t1_c4_empty", 32'(empty), 32'(1));
        check("t1_c4_req", 32'(req), 32'(0));
        check("t1_rt_cnt", 32'(rt_cnt), 32'(1));

        do_reset();
        grt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr(t2[i], 14'(i + 1), 1);
            @(negedge clk) check("t2_credit", 32'(credit), 32'(i == 3));
        end
        for (int c = 4; c < 10; c++) begin
            cyc(1);
            @(negedge clk) check("t2_credit", 32'(credit), 32'(c <= 6));
        end
        check("t2_rt_cnt", 32'(rt_cnt), 32'(1));
        check("t2_cr_cnt", 32'(cr_cnt), 32'(4));
        check("t2_full_seen", 32'(full_seen), 32'(0));
        check("t2_empty", 32'(empty), 32'(1));

        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr(t3[i], 14'(16 + i), i < 4);
            @(negedge clk);
            if (i == 3) check("t3_full_at3", 32'(full), 32'(0));
            if (i == 4) begin
                check("t3_full_at4", 32'(full), 32'(1));
                check("t3_ovf_at4", 32'(ovf), 32'(0));
            end
        end
        cyc(1);
        @(negedge clk) check("t3_ovf", 32'(ovf), 32'(1));
        check("t3_full", 32'(full), 32'(1));
        cr_cnt = 0;
        grt = 1'b1;
        cyc(6);
        @(negedge clk) check("t3_cr_cnt", 32'(cr_cnt), 32'(4));
        check("t3_empty", 32'(empty), 32'(1));
        check("t3_ovf_sticky", 32'(ovf), 32'(1));
        check("t3_req", 32'(req), 32'(0));

        do_reset();
        for (int i = 0; i < 4; i++) wr(t4[i], 14'(32 + i), 1);
        cyc(2);
        @(negedge clk) check("t4_full", 32'(full), 32'(1));
        check("t4_req", 32'(req), 32'(1));
        wr(TAIL, 14'h30, 1);
        grt = 1'b1;
        @(negedge clk) check("t4_credit", 32'(credit), 32'(1));
        cyc(1);
        grt = 1'b0;
        @(negedge clk) check("t4_full_kept", 32'(full), 32'(1));
        check("t4_ovf", 32'(ovf), 32'(0));
        check("t4_credit_off", 32'(credit), 32'(0));
        cr_cnt = 0;
        grt = 1'b1;
        cyc(8);
        @(negedge clk) check("t4_cr_cnt", 32'(cr_cnt), 32'(4));
        check("t4_empty", 32'(empty), 32'(1));
        check("t4_ovf_end", 32'(ovf), 32'(0));

        do_reset();
        wr(BODY, 14'h55, 1);
        @(negedge clk) check("t5_c0_credit", 32'(credit), 32'(0));
        cyc(1);
        @(negedge clk) check("t5_c1_credit", 32'(credit), 32'(1));
        check("t5_c1_err", 32'(err), 32'(0));
        cyc(1);
        @(negedge clk) check("t5_err", 32'(err), 32'(1));
        check("t5_empty", 32'(empty), 32'(1));
        cyc(3);
        check("t5_rt_cnt", 32'(rt_cnt), 32'(0));
        check("t5_cr_cnt", 32'(cr_cnt), 32'(1));

        do_reset();
        wr(HEAD, 14'h60, 1);
        wr(BODY, 14'h61, 1);
        wr(BODY, 14'h62, 1);
        cyc(1);
        grt = 1'b1;
        @(negedge clk) check("t6_credit", 32'(credit), 32'(1));
        cyc(1);
        grt = 1'b0;
        @(negedge clk) check("t6_req", 32'(req), 32'(1));
        check("t6_empty", 32'(empty), 32'(0));
        #2 grt = 1'b1;
        rst_ = 1'b0;
        #1;
        check("t6_async_empty", 32'(empty), 32'(1));
        check("t6_async_req", 32'(req), 32'(0));
        check("t6_async_credit", 32'(credit), 32'(0));
        sb.delete();
        cr_cnt = 0;
        rt_cnt = 0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_ = 1'b1;
        cyc(3);
        check("t6_no_credit", 32'(cr_cnt), 32'(0));
        check("t6_no_rt_en", 32'(rt_cnt), 32'(0));
        wr(HEADTAIL, 14'h70, 1);
        cyc(4);
        check("t6_restart_cr", 32'(cr_cnt), 32'(1));
        check("t6_restart_rt", 32'(rt_cnt), 32'(1));
        check("sb_drained", 32'(sb.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
